// File: rtl/fifo_ser_pkg.sv
// Shared types and configuration helpers for the FIFO read-side serializer.
//   state_e : serializer FSM states (IDLE = nothing held, SEND = word held)
//   ratio   : number of OUT_W slices in one DATA_W word
//   cfg_ok  : elaboration-time legality check of a width pairing
package fifo_ser_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    function automatic int ratio(input int data_w, input int out_w);
        return data_w / out_w;
    endfunction

    // A word must split into a whole number of slices, and at least two of
    // them, otherwise the slice counter has no meaningful width.
    function automatic bit cfg_ok(input int data_w, input int out_w);
        return (out_w > 0) && (data_w % out_w == 0) && (data_w / out_w >= 2);
    endfunction

endpackage

// File: rtl/fifo_rd_serializer.sv
// Read-side stage of the synchronous FIFO: pops wide words from the
// show-ahead read port and streams them out as OUT_W slices over a
// valid/ready interface, one slice per cycle, with no bubble between words
// while the FIFO stays non-empty.
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous, active-high reset
//   i_fifo_empty   FIFO empty flag
//   i_fifo_rddata  FIFO head word (valid while not empty)
//   o_fifo_rden    pop request, head advances at the next edge
//   o_valid        slice valid
//   o_data         current slice
//   o_last         current slice is the last one of its word
//   i_ready        sink accepts the slice when o_valid & i_ready
//   o_word_cnt     number of fully transferred words, wrapping
module fifo_rd_serializer
    import fifo_ser_pkg::*;
#(
    parameter int DATA_W    = 128,
    parameter int OUT_W     = 32,
    parameter bit MSB_FIRST = 1'b0,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_fifo_empty,
    input  logic [DATA_W-1:0] i_fifo_rddata,
    output logic              o_fifo_rden,
    output logic              o_valid,
    output logic [OUT_W-1:0]  o_data,
    output logic              o_last,
    input  logic              i_ready,
    output logic [CNT_W-1:0]  o_word_cnt
);

    localparam int RATIO  = ratio(DATA_W, OUT_W);
    localparam int SLC_W  = $clog2(RATIO);
    localparam int BASE_W = $clog2(DATA_W);
    localparam logic [SLC_W-1:0] SLC_LAST = SLC_W'(RATIO - 1);

    if (!cfg_ok(DATA_W, OUT_W)) begin : g_cfg_check
        $error("fifo_rd_serializer: DATA_W must be a multiple of OUT_W with at least 2 slices");
    end

    state_e             state_rg;
    state_e             state_nx;
    logic [DATA_W-1:0]  word_rg;
    logic [SLC_W-1:0]   slc_rg;
    logic [CNT_W-1:0]   cnt_rg;

    logic               hold_vld;
    logic               last;
    logic               acc;
    logic               done;
    logic               pop;
    logic [SLC_W-1:0]   idx;
    logic [BASE_W-1:0]  base;

    assign hold_vld = (state_rg == SEND);
    assign last     = hold_vld && (slc_rg == SLC_LAST);
    assign acc      = hold_vld && i_ready;
    assign done     = acc && last;

    // A new word is fetched either into an empty holder or in the very cycle
    // the final slice of the current word is accepted, which is what removes
    // the bubble between consecutive words.
    assign pop = !rst && !i_fifo_empty && (!hold_vld || done);

    // Slice mux: the counter always runs upward; MSB-first order just mirrors
    // the index so the top slice goes out first.
    assign idx  = MSB_FIRST ? (SLC_LAST - slc_rg) : slc_rg;
    assign base = BASE_W'(idx) * BASE_W'(OUT_W);

    assign o_fifo_rden = pop;
    assign o_valid     = hold_vld;
    assign o_last      = last;
    assign o_data      = word_rg[base +: OUT_W];
    assign o_word_cnt  = cnt_rg;

    // NOTE: every variable driven in always_comb gets a default before any
    // branch so no path can leave it unassigned and infer a latch.
    always_comb begin
        state_nx = state_rg;
        case (state_rg)
            IDLE:    if (pop) state_nx = SEND;
            SEND:    if (done && !pop) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so all
    // registers update together from values sampled before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_rg <= IDLE;
            word_rg  <= '0;
            slc_rg   <= '0;
            cnt_rg   <= '0;
        end else begin
            state_rg <= state_nx;
            // A pop restarts the slice counter even when it coincides with
            // the last-slice acceptance of the previous word.
            if (pop) begin
                word_rg <= i_fifo_rddata;
                slc_rg  <= '0;
            end else if (acc && !last) begin
                slc_rg <= slc_rg + SLC_W'(1);
            end
            if (done) begin
                cnt_rg <= cnt_rg + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_serializer.sv
// Self-checking bench for fifo_rd_serializer. Two instances share the same
// FIFO and sink stimulus: one LSB-first with a 16-bit counter, one MSB-first
// with a 3-bit counter so counter wrap is reached quickly. A reference model
// tracks the held word, slices sent and words completed, and predicts every
// output each cycle.
module tb_fifo_rd_serializer;

    localparam int DATA_W = 128;
    localparam int OUT_W  = 32;
    localparam int RATIO  = DATA_W / OUT_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_fifo_empty = 1'b1;
    logic [DATA_W-1:0] i_fifo_rddata = '0;
    logic              i_ready = 1'b0;

    logic              a_rden, a_valid, a_last;
    logic [OUT_W-1:0]  a_data;
    logic [15:0]       a_cnt;
    logic              b_rden, b_valid, b_last;
    logic [OUT_W-1:0]  b_data;
    logic [2:0]        b_cnt;

    always #5 clk = ~clk;

    fifo_rd_serializer #(.DATA_W(DATA_W), .OUT_W(OUT_W), .MSB_FIRST(1'b0), .CNT_W(16)) dut_lsb (
        .clk(clk), .rst(rst), .i_fifo_empty(i_fifo_empty), .i_fifo_rddata(i_fifo_rddata),
        .o_fifo_rden(a_rden), .o_valid(a_valid), .o_data(a_data), .o_last(a_last),
        .i_ready(i_ready), .o_word_cnt(a_cnt)
    );

    fifo_rd_serializer #(.DATA_W(DATA_W), .OUT_W(OUT_W), .MSB_FIRST(1'b1), .CNT_W(3)) dut_msb (
        .clk(clk), .rst(rst), .i_fifo_empty(i_fifo_empty), .i_fifo_rddata(i_fifo_rddata),
        .o_fifo_rden(b_rden), .o_valid(b_valid), .o_data(b_data), .o_last(b_last),
        .i_ready(i_ready), .o_word_cnt(b_cnt)
    );

    // FIFO contents and reference model state
    logic [DATA_W-1:0] fq[$];
    bit                m_busy = 1'b0;
    logic [DATA_W-1:0] m_word = '0;
    int                m_slc  = 0;
    int                m_cnt  = 0;

    // observation vectors: {rden, valid, last, data, cnt}
    logic [50:0] exp_a, exp_b, obs_a, obs_b;
    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    function automatic logic [OUT_W-1:0] slice_of(input logic [DATA_W-1:0] w, input int k, input bit msb);
        int pos;
        pos = msb ? (RATIO - 1 - k) : k;
        return OUT_W'(w >> (OUT_W * pos));
    endfunction

    // One clock cycle: drive inputs after the edge, sample at the falling
    // edge, form predictions, then advance the model to the next edge.
    task automatic step(input logic r, input logic rdy);
        logic e_last, e_rden;
        @(posedge clk);
        #1;
        rst          = r;
        i_ready      = rdy;
        i_fifo_empty = (fq.size() == 0);
        i_fifo_rddata = i_fifo_empty ? {4{$urandom()}} : fq[0];
        @(negedge clk);
        cyc++;
        e_last = m_busy && (m_slc == RATIO - 1);
        e_rden = !r && !i_fifo_empty && (!m_busy || (e_last && rdy));
        exp_a = {e_rden, m_busy, e_last, slice_of(m_word, m_slc, 1'b0), 16'(m_cnt)};
        exp_b = {e_rden, m_busy, e_last, slice_of(m_word, m_slc, 1'b1), 16'(m_cnt % 8)};
        obs_a = {a_rden, a_valid, a_last, a_data, a_cnt};
        obs_b = {b_rden, b_valid, b_last, b_data, 16'(b_cnt)};
        if (r) begin
            m_busy = 1'b0;
            m_word = '0;
            m_slc  = 0;
            m_cnt  = 0;
        end else begin
            if (m_busy && rdy) begin
                if (e_last) begin
                    m_cnt++;
                    m_busy = 1'b0;
                end else begin
                    m_slc++;
                end
            end
            if (e_rden) begin
                m_word = fq.pop_front();
                m_slc  = 0;
                m_busy = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        for (int c = 0; c < 4; c++) begin
            step(1'b1, 1'($urandom_range(0, 1)));
            n_vec += 2;
            if (obs_a !== exp_a) begin n_err++; $display("FAIL reset lsb cyc=%0d got=%h exp=%h", cyc, obs_a, exp_a); end
            if (obs_b !== exp_b) begin n_err++; $display("FAIL reset msb cyc=%0d got=%h exp=%h", cyc, obs_b, exp_b); end
        end
        // explicit reset values, independent of the model
        n_vec++;
        if ({a_valid, a_data, a_last, a_rden, a_cnt} !== '0) begin
            n_err++;
            $display("FAIL reset_values got=%h exp=0", {a_valid, a_data, a_last, a_rden, a_cnt});
        end
    endtask

    task automatic test_single_word();
        logic [OUT_W-1:0] sa[$];
        logic [OUT_W-1:0] sb[$];
        int lasts;
        lasts = 0;
        fq.push_back(128'h4444_4444_3333_3333_2222_2222_1111_1111);
        for (int c = 0; c < 7; c++) begin
            step(1'b0, 1'b1);
            n_vec += 2;
            if (obs_a !== exp_a) begin n_err++; $display("FAIL single lsb cyc=%0d got=%h exp=%h", cyc, obs_a, exp_a); end
            if (obs_b !== exp_b) begin n_err++; $display("FAIL single msb cyc=%0d got=%h exp=%h", cyc, obs_b, exp_b); end
            if (a_valid === 1'b1) begin
                sa.push_back(a_data);
                sb.push_back(b_data);
                if (a_last === 1'b1) lasts = lasts + (sa.size() == 4 ? 1 : 100);
            end
        end
        n_vec++;
        if (sa.size() != 4 || sb.size() != 4 || lasts != 1) begin
            n_err++;
            $display("FAIL single_count got=%0d/%0d slices last=%0d exp=4/4 last=1", sa.size(), sb.size(), lasts);
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_vec += 2;
                if (sa[k] !== 32'h1111_1111 * (k + 1)) begin
                    n_err++; $display("FAIL single_lsb_slice%0d got=%h exp=%h", k, sa[k], 32'h1111_1111 * (k + 1));
                end
                if (sb[k] !== 32'h1111_1111 * (4 - k)) begin
                    n_err++; $display("FAIL single_msb_slice%0d got=%h exp=%h", k, sb[k], 32'h1111_1111 * (4 - k));
                end
            end
        end
        n_vec++;
        if (a_cnt !== 16'd1) begin n_err++; $display("FAIL single_cnt got=%0d exp=1", a_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] rden_mask, valid_mask;
        logic [15:0] cnt0;
        rden_mask  = '0;
        valid_mask = '0;
        cnt0       = a_cnt;
        for (int w = 0; w < 3; w++) fq.push_back({$urandom(), $urandom(), $urandom(), $urandom()});
        for (int c = 0; c < 14; c++) begin
            step(1'b0, 1'b1);
            n_vec += 2;
            if (obs_a !== exp_a) begin n_err++; $display("FAIL b2b lsb cyc=%0d got=%h exp=%h", cyc, obs_a, exp_a); end
            if (obs_b !== exp_b) begin n_err++; $display("FAIL b2b msb cyc=%0d got=%h exp=%h", cyc, obs_b, exp_b); end
            rden_mask[c]  = a_rden;
            valid_mask[c] = a_valid;
        end
        n_vec += 3;
        if (rden_mask !== 16'h0111) begin n_err++; $display("FAIL b2b_rden got=%h exp=0111", rden_mask); end
        if (valid_mask !== 16'h1ffe) begin n_err++; $display("FAIL b2b_valid got=%h exp=1ffe", valid_mask); end
        if (a_cnt !== cnt0 + 16'd3) begin n_err++; $display("FAIL b2b_cnt got=%0d exp=%0d", a_cnt, cnt0 + 16'd3); end
    endtask

    task automatic test_stall();
        logic [DATA_W-1:0] words[2];
        logic [OUT_W-1:0]  got[$];
        logic [OUT_W-1:0]  pdata;
        logic              plast, pstall;
        pstall = 1'b0;
        pdata  = '0;
        plast  = 1'b0;
        for (int w = 0; w < 2; w++) begin
            words[w] = {$urandom(), $urandom(), $urandom(), $urandom()};
            fq.push_back(words[w]);
        end
        for (int c = 0; c < 24; c++) begin
            step(1'b0, (c % 4 == 0) || (c % 4 == 3));
            n_vec += 2;
            if (obs_a !== exp_a) begin n_err++; $display("FAIL stall lsb cyc=%0d got=%h exp=%h", cyc, obs_a, exp_a); end
            if (obs_b !== exp_b) begin n_err++; $display("FAIL stall msb cyc=%0d got=%h exp=%h", cyc, obs_b, exp_b); end
            if (pstall) begin
                n_vec++;
                if (a_valid !== 1'b1 || a_data !== pdata || a_last !== plast) begin
                    n_err++;
                    $display("FAIL stall_hold cyc=%0d got=%b/%h/%b exp=1/%h/%b", cyc, a_valid, a_data, a_last, pdata, plast);
                end
            end
            if (a_valid === 1'b1 && i_ready === 1'b1) got.push_back(a_data);
            pstall = (a_valid === 1'b1) && !i_ready;
            pdata  = a_data;
            plast  = a_last;
        end
        n_vec++;
        if (got.size() != 8) begin
            n_err++; $display("FAIL stall_count got=%0d exp=8", got.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                n_vec++;
                if (got[k] !== slice_of(words[k / 4], k % 4, 1'b0)) begin
                    n_err++; $display("FAIL stall_seq%0d got=%h exp=%h", k, got[k], slice_of(words[k / 4], k % 4, 1'b0));
                end
            end
        end
    endtask

    task automatic test_reset_mid_word();
        logic [DATA_W-1:0] w2;
        bit seen;
        seen = 1'b0;
        w2 = {$urandom(), $urandom(), $urandom(), $urandom()};
        fq.push_back({$urandom(), $urandom(), $urandom(), $urandom()});
        fq.push_back(w2);
        // pop, then accept two slices, then reset for two cycles
        for (int c = 0; c < 5; c++) begin
            step(c >= 3, 1'b1);
            n_vec += 2;
            if (obs_a !== exp_a) begin n_err++; $display("FAIL midrst lsb cyc=%0d got=%h exp=%h", cyc, obs_a, exp_a); end
            if (obs_b !== exp_b) begin n_err++; $display("FAIL midrst msb cyc=%0d got=%h exp=%h", cyc, obs_b, exp_b); end
        end
        n_vec += 2;
        if ({a_valid, a_rden, a_cnt} !== '0) begin
            n_err++; $display("FAIL midrst_state got=%h exp=0", {a_valid, a_rden, a_cnt});
        end
        if (fq.size() != 1) begin n_err++; $display("FAIL midrst_fifo got=%0d words exp=1", fq.size()); end
        for (int c = 0; c < 6; c++) begin
            step(1'b0, 1'b1);
            n_vec += 2;
            if (obs_a !== exp_a) begin n_err++; $display("FAIL midrst2 lsb cyc=%0d got=%h exp=%h", cyc, obs_a, exp_a); end
            if (obs_b !== exp_b) begin n_err++; $display("FAIL midrst2 msb cyc=%0d got=%h exp=%h", cyc, obs_b, exp_b); end
            if (a_valid === 1'b1 && !seen) begin
                seen = 1'b1;
                n_vec++;
                if (a_data !== w2[31:0]) begin n_err++; $display("FAIL midrst_restart got=%h exp=%h", a_data, w2[31:0]); end
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            if (fq.size() < 4 && $urandom_range(0, 2) == 0)
                fq.push_back({$urandom(), $urandom(), $urandom(), $urandom()});
            step($urandom_range(0, 149) == 0, $urandom_range(0, 3) != 0);
            n_vec += 2;
            if (obs_a !== exp_a) begin n_err++; $display("FAIL random lsb cyc=%0d got=%h exp=%h", cyc, obs_a, exp_a); end
            if (obs_b !== exp_b) begin n_err++; $display("FAIL random msb cyc=%0d got=%h exp=%h", cyc, obs_b, exp_b); end
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_stall();
        test_reset_mid_word();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
